// File: rtl/lcd_dec_formatter.sv
// rtl/lcd_dec_formatter.sv - sequential double-dabble binary-to-ASCII feeder for a 2x6 LCD
module lcd_dec_formatter #(
    parameter logic [7:0] PREFIX      = 8'h20,
    parameter bit         BLANK_ZEROS = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        i_start,
    input  logic [15:0] i_value0,
    input  logic [15:0] i_value1,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  d0x0,
    output logic [7:0]  d0x1,
    output logic [7:0]  d0x2,
    output logic [7:0]  d0x3,
    output logic [7:0]  d0x4,
    output logic [7:0]  d0x5,
    output logic [7:0]  d1x0,
    output logic [7:0]  d1x1,
    output logic [7:0]  d1x2,
    output logic [7:0]  d1x3,
    output logic [7:0]  d1x4,
    output logic [7:0]  d1x5
);

    typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] bin0;
    logic [15:0] bin1;
    logic [19:0] bcd0;
    logic [19:0] bcd1;
    logic [4:0]  cnt;
    logic [47:0] line0;
    logic [47:0] line1;
    logic        done;
    logic [35:0] shifted0;
    logic [35:0] shifted1;

    // Pre-shift correction: any BCD digit of 5 or more gets 3 added so it carries correctly.
    function automatic logic [19:0] add3(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Packs a line as {x0..x5}: prefix, then ten-thousands down to units, leading zeros optionally blanked.
    function automatic logic [47:0] to_ascii(input logic [19:0] b);
        logic [47:0] r;
        logic        lead;
        logic [3:0]  digit;
        r          = '0;
        r[47:40]   = PREFIX;
        lead       = BLANK_ZEROS;
        for (int i = 0; i < 5; i++) begin
            digit = b[19-4*i -: 4];
            if (lead && (digit == 4'd0) && (i < 4)) begin
                r[39-8*i -: 8] = 8'h20;
            end else begin
                r[39-8*i -: 8] = {4'h3, digit};
                lead           = 1'b0;
            end
        end
        return r;
    endfunction

    assign shifted0 = {add3(bcd0), bin0} << 1;
    assign shifted1 = {add3(bcd1), bin1} << 1;

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: sixteen shifts, then one write cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = SHIFT;
            SHIFT:   if (cnt == 5'd15) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state and the registered done flag.
    always_comb begin
        o_busy = (state != IDLE);
        o_done = done;
    end

    // Datapath: capture, shift-add-3 per clock, and registered character update at WRITE.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bin0  <= '0;
            bin1  <= '0;
            bcd0  <= '0;
            bcd1  <= '0;
            cnt   <= '0;
            line0 <= {6{8'h20}};
            line1 <= {6{8'h20}};
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        bin0 <= i_value0;
                        bin1 <= i_value1;
                        bcd0 <= '0;
                        bcd1 <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    bcd0 <= shifted0[35:16];
                    bin0 <= shifted0[15:0];
                    bcd1 <= shifted1[35:16];
                    bin1 <= shifted1[15:0];
                    cnt  <= cnt + 5'd1;
                end
                WRITE: begin
                    line0 <= to_ascii(bcd0);
                    line1 <= to_ascii(bcd1);
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign {d0x0, d0x1, d0x2, d0x3, d0x4, d0x5} = line0;
    assign {d1x0, d1x1, d1x2, d1x3, d1x4, d1x5} = line1;

endmodule

// File: tb/tb_lcd_dec_formatter.sv
// tb/tb_lcd_dec_formatter.sv - self-checking bench for lcd_dec_formatter
module tb_lcd_dec_formatter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] v0 = '0;
    logic [15:0] v1 = '0;

    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] a00, a01, a02, a03, a04, a05, a10, a11, a12, a13, a14, a15;
    logic [7:0] b00, b01, b02, b03, b04, b05, b10, b11, b12, b13, b14, b15;
    logic [47:0] la0, la1, lb0, lb1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcd_dec_formatter dut_a (
        .iCLK(clk), .iRST_N(rst_n), .i_start(start), .i_value0(v0), .i_value1(v1),
        .o_busy(busy_a), .o_done(done_a),
        .d0x0(a00), .d0x1(a01), .d0x2(a02), .d0x3(a03), .d0x4(a04), .d0x5(a05),
        .d1x0(a10), .d1x1(a11), .d1x2(a12), .d1x3(a13), .d1x4(a14), .d1x5(a15)
    );

    lcd_dec_formatter #(.PREFIX(8'h2B), .BLANK_ZEROS(1'b0)) dut_b (
        .iCLK(clk), .iRST_N(rst_n), .i_start(start), .i_value0(v0), .i_value1(v1),
        .o_busy(busy_b), .o_done(done_b),
        .d0x0(b00), .d0x1(b01), .d0x2(b02), .d0x3(b03), .d0x4(b04), .d0x5(b05),
        .d1x0(b10), .d1x1(b11), .d1x2(b12), .d1x3(b13), .d1x4(b14), .d1x5(b15)
    );

    assign la0 = {a00, a01, a02, a03, a04, a05};
    assign la1 = {a10, a11, a12, a13, a14, a15};
    assign lb0 = {b00, b01, b02, b03, b04, b05};
    assign lb1 = {b10, b11, b12, b13, b14, b15};

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected six-character line straight from decimal arithmetic.
    function automatic logic [47:0] fmt(input int v, input logic [7:0] pre, input bit blank);
        logic [47:0] r;
        int p;
        bit lead;
        r = '0;
        r[47:40] = pre;
        lead = blank;
        p = 10000;
        for (int i = 1; i <= 5; i++) begin
            int d;
            d = (v / p) % 10;
            if (lead && d == 0 && i < 5) r[47-8*i -: 8] = 8'h20;
            else begin
                r[47-8*i -: 8] = 8'(48 + d);
                lead = 1'b0;
            end
            p = p / 10;
        end
        return r;
    endfunction

    // Reference model: a conversion occupies 17 busy cycles, then characters update with a done pulse.
    int          m_cnt;
    logic        m_done;
    logic [15:0] m_v0, m_v1;
    logic [47:0] m_a0, m_a1, m_b0, m_b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_a0   <= {6{8'h20}};
            m_a1   <= {6{8'h20}};
            m_b0   <= {6{8'h20}};
            m_b1   <= {6{8'h20}};
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_v0  <= v0;
                    m_v1  <= v1;
                    m_cnt <= 17;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_a0   <= fmt(int'(m_v0), 8'h20, 1'b1);
                    m_a1   <= fmt(int'(m_v1), 8'h20, 1'b1);
                    m_b0   <= fmt(int'(m_v0), 8'h2B, 1'b0);
                    m_b1   <= fmt(int'(m_v1), 8'h2B, 1'b0);
                end
            end
        end
    end

    bit cmp_en = 1'b0;

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy_a", 48'(busy_a), 48'(m_cnt != 0));
            chk("done_a", 48'(done_a), 48'(m_done));
            chk("busy_b", 48'(busy_b), 48'(m_cnt != 0));
            chk("done_b", 48'(done_b), 48'(m_done));
            chk("line0_a", la0, m_a0);
            chk("line1_a", la1, m_a1);
            chk("line0_b", lb0, m_b0);
            chk("line1_b", lb1, m_b1);
        end
    end

    task automatic pulse(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        v0 = a;
        v1 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 40) begin
            if (done_a) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("done_seen", 48'(ok), 48'd1);
    endtask

    function automatic logic [15:0] rnd();
        int k;
        k = $urandom_range(0, 17);
        if (k == 17) return 16'hFFFF;
        return 16'($urandom & ((1 << k) - 1));
    endfunction

    int n, dn;

    initial begin
        chk("fmt_pin_12345", fmt(12345, 8'h20, 1'b1), 48'h203132333435);
        chk("fmt_pin_1007", fmt(1007, 8'h20, 1'b1), 48'h202031303037);
        chk("fmt_pin_42nb", fmt(42, 8'h2B, 1'b0), 48'h2B3030303432);

        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_line0", la0, {6{8'h20}});
        chk("rst_line1", la1, {6{8'h20}});
        chk("rst_busy", 48'(busy_a), 48'd0);

        pulse(16'd12345, 16'd0);
        wait_done(n);
        chk("latency", 48'(n), 48'd17);
        chk("t2_line0", la0, 48'h203132333435);
        chk("t2_line1", la1, 48'h202020202030);

        pulse(16'd65535, 16'd1007);
        wait_done(n);
        chk("t3_line0", la0, 48'h203635353335);
        chk("t3_line1", la1, 48'h202031303037);

        pulse(16'd42, 16'd7);
        wait_done(n);
        chk("t4_line0_b", lb0, 48'h2B3030303432);
        chk("t4_line0_a", la0, 48'h202020203432);

        // Extra start pulses and value changes while busy are ignored.
        pulse(16'd500, 16'd3);
        n = 1;
        dn = 0;
        while (!done_a && n < 40) begin
            if (n == 3 || n == 10) begin
                start = 1'b1;
                v0 = 16'd9;
            end else start = 1'b0;
            @(negedge clk);
            n++;
            if (done_a) dn++;
        end
        chk("t5_done_cycle", 48'(n), 48'd18);
        chk("t5_done_count", 48'(dn), 48'd1);
        chk("t5_line0", la0, 48'h202020353030);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_restart_busy", 48'(busy_a), 48'd1);
        chk("t5_line0_hold", la0, 48'h202020353030);
        wait_done(n);

        // Reset in the middle of a conversion aborts it.
        pulse(16'd54321, 16'd999);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a) dn++;
        end
        chk("t6_no_done", 48'(dn), 48'd0);
        chk("t6_line0", la0, {6{8'h20}});
        chk("t6_line1", la1, {6{8'h20}});
        pulse(16'd7, 16'd0);
        wait_done(n);
        chk("t6_line0_after", la0, 48'h202020202037);

        // Random traffic against the model, with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) v0 = rnd();
            if ($urandom_range(0, 2) == 0) v1 = rnd();
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (25) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
